sequenciador_fases: RTL and testbench

Multicycle phase sequencer for the single-issue MIPS core: replaces the fixed 9-step phase counter in the top level with an opcode-aware FSM. It pulses the per-stage enables for instruction fetch, field capture, control decode, register read, ALU-control, execute, memory and write-back, skipping phases an opcode does not need. It also waits on a memory-ready handshake with timeout, and keeps the retired-instruction count that drives the fetch address.

---
 rtl/pacote_processador.sv | 23 ++
 rtl/sequenciador_fases.sv | 131 +++++++++++++
 tb/tb_sequenciador_fases.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pacote_processador.sv
// Shared definitions for the multicycle MIPS core: phase state codes and
// the opcodes the phase sequencer needs to tell apart.
package pacote_processador;

   typedef enum logic [3:0] {
      S_INICIO   = 4'd0,
      S_BUSCA    = 4'd1,
      S_CAPTURA  = 4'd2,
      S_CONTROLE = 4'd3,
      S_LEITURA  = 4'd4,
      S_ALUCTRL  = 4'd5,
      S_EXEC     = 4'd6,
      S_MEM      = 4'd7,
      S_ESCRITA  = 4'd8,
      S_FIM      = 4'd9
   } estado_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

endpackage

// File: rtl/sequenciador_fases.sv
// Opcode-aware phase sequencer. Moore FSM that pulses one stage enable per
// cycle, skips MEM/ESCRITA when the opcode does not need them, waits on the
// memory-ready handshake with a timeout and counts retired instructions.
module sequenciador_fases
   import pacote_processador::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        habilita,
   input  logic [5:0]  opcode,
   input  logic        mem_pronto,
   output logic        ifd,
   output logic        captura,
   output logic        co,
   output logic        id,
   output logic        pc_we,
   output logic        ic,
   output logic        alu,
   output logic        mem,
   output logic        fim_instr,
   output logic        erro_mem,
   output logic [3:0]  fase,
   output logic [31:0] num_instr
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_ULTIMO = CW'(MEM_TIMEOUT - 1);

   estado_t       state_q, state_d;
   logic [5:0]    op_reg_q, op_reg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          erro_q, erro_d;
   logic [31:0]   num_instr_q, num_instr_d;

   // Last allowed MEM cycle without a ready: this cycle ends the access.
   logic          mem_estouro;
   assign mem_estouro = (cnt_q == CNT_ULTIMO) && !mem_pronto;

   // State and datapath registers; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_INICIO;
         op_reg_q    <= '0;
         cnt_q       <= '0;
         erro_q      <= 1'b0;
         num_instr_q <= '0;
      end else begin
         state_q     <= state_d;
         op_reg_q    <= op_reg_d;
         cnt_q       <= cnt_d;
         erro_q      <= erro_d;
         num_instr_q <= num_instr_d;
      end
   end

   // Next-state selection; unused codes fall back to INICIO.
   always_comb begin
      state_d = S_INICIO;
      case (state_q)
         S_INICIO:   state_d = habilita ? S_BUSCA : S_INICIO;
         S_BUSCA:    state_d = S_CAPTURA;
         S_CAPTURA:  state_d = S_CONTROLE;
         S_CONTROLE: state_d = S_LEITURA;
         S_LEITURA:  state_d = S_ALUCTRL;
         S_ALUCTRL:  state_d = S_EXEC;
         S_EXEC: begin
            if (op_reg_q == OP_LW || op_reg_q == OP_SW) state_d = S_MEM;
            else if (op_reg_q == OP_BEQ)                state_d = S_FIM;
            else                                        state_d = S_ESCRITA;
         end
         S_MEM: begin
            if (mem_pronto)       state_d = (op_reg_q == OP_LW) ? S_ESCRITA : S_FIM;
            else if (mem_estouro) state_d = S_FIM;
            else                  state_d = S_MEM;
         end
         S_ESCRITA:  state_d = S_FIM;
         S_FIM:      state_d = habilita ? S_BUSCA : S_INICIO;
         default:    state_d = S_INICIO;
      endcase
   end

   // Opcode latch, MEM wait counter, sticky timeout flag and retire counter.
   always_comb begin
      op_reg_d    = op_reg_q;
      cnt_d       = cnt_q;
      erro_d      = erro_q;
      num_instr_d = num_instr_q;
      if (state_q == S_CAPTURA) op_reg_d = opcode;
      if (state_q == S_MEM) begin
         if (mem_pronto || mem_estouro) cnt_d = '0;
         else                           cnt_d = cnt_q + 1'b1;
         if (mem_estouro) erro_d = 1'b1;
      end
      if (state_q == S_FIM) num_instr_d = num_instr_q + 32'd1;
   end

   // Stage enables decoded from the state register alone.
   always_comb begin
      ifd       = 1'b0;
      captura   = 1'b0;
      co        = 1'b0;
      id        = 1'b0;
      pc_we     = 1'b0;
      ic        = 1'b0;
      alu       = 1'b0;
      mem       = 1'b0;
      fim_instr = 1'b0;
      case (state_q)
         S_BUSCA:    ifd = 1'b1;
         S_CAPTURA:  captura = 1'b1;
         S_CONTROLE: co = 1'b1;
         S_LEITURA: begin
            id    = 1'b1;
            pc_we = 1'b1;
         end
         S_ALUCTRL:  ic = 1'b1;
         S_EXEC:     alu = 1'b1;
         S_MEM:      mem = 1'b1;
         S_ESCRITA:  id = 1'b1;
         S_FIM:      fim_instr = 1'b1;
         default: ;
      endcase
   end

   assign fase      = state_q;
   assign erro_mem  = erro_q;
   assign num_instr = num_instr_q;

endmodule

// File: tb/tb_sequenciador_fases.sv
// Directed bench for the phase sequencer: traces the phase code of each
// instruction class and checks enables, counters and the timeout flag.
module tb_sequenciador_fases;

   logic        clk, reset, habilita, mem_pronto;
   logic [5:0]  opcode;
   logic        ifd, captura, co, id, pc_we, ic, alu, mem, fim_instr, erro_mem;
   logic [3:0]  fase;
   logic [31:0] num_instr;

   int nvec = 0;
   int nerr = 0;

   logic [3:0]  tr [0:31];
   int          tr_len, waits, n_mem, n_id, n_ifd, n_fim, n_pcwe, hot_err;
   logic [31:0] num_before, num_after;
   logic [3:0]  fase_after;

   sequenciador_fases #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .habilita(habilita), .opcode(opcode),
      .mem_pronto(mem_pronto), .ifd(ifd), .captura(captura), .co(co),
      .id(id), .pc_we(pc_we), .ic(ic), .alu(alu), .mem(mem),
      .fim_instr(fim_instr), .erro_mem(erro_mem), .fase(fase),
      .num_instr(num_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Traces one instruction from BUSCA through FIM, ending one cycle after FIM.
   // pronto_at: MEM cycle (1-based) on which mem_pronto rises, 0 = never.
   task automatic capture(input logic [5:0] op, input int pronto_at,
                          input bit drop_exec, input bit do_force);
      int memc;
      bit done;
      opcode = op;
      waits = 0;
      while (fase !== 4'd1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 40) begin
         nvec++; nerr++;
         $display("FAIL capture_start: fase=%0d never reached BUSCA", fase);
      end
      tr_len = 0; memc = 0; done = 0;
      n_mem = 0; n_id = 0; n_ifd = 0; n_fim = 0; n_pcwe = 0; hot_err = 0;
      num_before = num_instr;
      while (!done && tr_len < 32) begin
         tr[tr_len] = fase;
         tr_len++;
         n_mem += int'(mem); n_id += int'(id); n_ifd += int'(ifd);
         n_fim += int'(fim_instr); n_pcwe += int'(pc_we);
         if (int'(ifd) + int'(captura) + int'(co) + int'(id) + int'(ic)
             + int'(alu) + int'(mem) > 1) hot_err++;
         if (fase == 4'd7) begin
            memc++;
            mem_pronto = (memc == pronto_at);
         end else begin
            mem_pronto = 1'b1;
         end
         if (drop_exec && fase == 4'd6) habilita = 1'b0;
         if (do_force && fase == 4'd2) force dut.num_instr_q = 32'hFFFF_FFFF;
         if (do_force && fase == 4'd4) release dut.num_instr_q;
         if (fase == 4'd9) done = 1;
         @(negedge clk);
      end
      mem_pronto = 1'b0;
      num_after  = num_instr;
      fase_after = fase;
   endtask

   task automatic test_reset();
      reset = 1'b0; habilita = 1'b0; opcode = '0; mem_pronto = 1'b0;
      #12;
      nvec++;
      if ({ifd, captura, co, id, pc_we, ic, alu, mem, fim_instr} !== 9'd0 || fase !== 4'd0) begin
         nerr++; $display("FAIL reset_outputs: enables=%b fase=%0d want 0/0",
            {ifd, captura, co, id, pc_we, ic, alu, mem, fim_instr}, fase);
      end
      nvec++;
      if (num_instr !== 32'd0 || erro_mem !== 1'b0) begin
         nerr++; $display("FAIL reset_counters: num=%0d erro=%b want 0/0", num_instr, erro_mem);
      end
      @(negedge clk); reset = 1'b1;
      @(negedge clk); @(negedge clk);
      nvec++;
      if (fase !== 4'd0) begin
         nerr++; $display("FAIL idle_without_habilita: fase=%0d want 0", fase);
      end
      habilita = 1'b1;
      @(negedge clk);
      nvec++;
      if (fase !== 4'd1 || ifd !== 1'b1) begin
         nerr++; $display("FAIL first_busca: fase=%0d ifd=%b want 1/1", fase, ifd);
      end
   endtask

   task automatic test_rtype();
      int e[8] = '{1, 2, 3, 4, 5, 6, 8, 9};
      capture(6'b000000, 0, 0, 0);
      nvec++;
      if (tr_len != 8) begin nerr++; $display("FAIL rtype_len: got %0d want 8", tr_len); end
      for (int i = 0; i < 8; i++) begin
         nvec++;
         if (tr[i] !== 4'(e[i])) begin
            nerr++; $display("FAIL rtype_seq[%0d]: got %0d want %0d", i, tr[i], e[i]);
         end
      end
      nvec++;
      if (n_id != 2 || n_pcwe != 1 || n_mem != 0 || hot_err != 0) begin
         nerr++; $display("FAIL rtype_enables: id=%0d pc_we=%0d mem=%0d hot=%0d want 2/1/0/0",
            n_id, n_pcwe, n_mem, hot_err);
      end
      nvec++;
      if (num_before !== 32'd0 || num_after !== 32'd1) begin
         nerr++; $display("FAIL rtype_count: %0d->%0d want 0->1", num_before, num_after);
      end
   endtask

   task automatic test_lw();
      int e[11] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 8, 9};
      capture(6'b100011, 3, 0, 0);
      nvec++;
      if (waits != 0) begin nerr++; $display("FAIL back_to_back: idle=%0d want 0", waits); end
      nvec++;
      if (tr_len != 11) begin nerr++; $display("FAIL lw_len: got %0d want 11", tr_len); end
      for (int i = 0; i < 11; i++) begin
         nvec++;
         if (tr[i] !== 4'(e[i])) begin
            nerr++; $display("FAIL lw_seq[%0d]: got %0d want %0d", i, tr[i], e[i]);
         end
      end
      nvec++;
      if (n_mem != 3 || hot_err != 0 || erro_mem !== 1'b0) begin
         nerr++; $display("FAIL lw_mem: mem=%0d hot=%0d erro=%b want 3/0/0", n_mem, hot_err, erro_mem);
      end
      nvec++;
      if (num_after !== 32'd2) begin nerr++; $display("FAIL lw_count: got %0d want 2", num_after); end
   endtask

   task automatic test_sw();
      int e[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
      capture(6'b101011, 1, 0, 0);
      nvec++;
      if (tr_len != 8) begin nerr++; $display("FAIL sw_len: got %0d want 8", tr_len); end
      for (int i = 0; i < 8; i++) begin
         nvec++;
         if (tr[i] !== 4'(e[i])) begin
            nerr++; $display("FAIL sw_seq[%0d]: got %0d want %0d", i, tr[i], e[i]);
         end
      end
      nvec++;
      if (n_id != 1 || n_mem != 1) begin
         nerr++; $display("FAIL sw_enables: id=%0d mem=%0d want 1/1", n_id, n_mem);
      end
   endtask

   task automatic test_beq();
      int e[7] = '{1, 2, 3, 4, 5, 6, 9};
      capture(6'b000100, 1, 0, 0);
      nvec++;
      if (tr_len != 7) begin nerr++; $display("FAIL beq_len: got %0d want 7", tr_len); end
      for (int i = 0; i < 7; i++) begin
         nvec++;
         if (tr[i] !== 4'(e[i])) begin
            nerr++; $display("FAIL beq_seq[%0d]: got %0d want %0d", i, tr[i], e[i]);
         end
      end
      nvec++;
      if (n_id != 1 || n_mem != 0 || n_fim != 1) begin
         nerr++; $display("FAIL beq_enables: id=%0d mem=%0d fim=%0d want 1/0/1", n_id, n_mem, n_fim);
      end
      nvec++;
      if (num_after !== 32'd4) begin nerr++; $display("FAIL beq_count: got %0d want 4", num_after); end
   endtask

   task automatic test_timeout();
      int e[10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
      capture(6'b100011, 0, 0, 0);
      nvec++;
      if (tr_len != 11) begin nerr++; $display("FAIL to_len: got %0d want 11", tr_len); end
      for (int i = 0; i < 10; i++) begin
         nvec++;
         if (tr[i] !== 4'(e[i])) begin
            nerr++; $display("FAIL to_seq[%0d]: got %0d want %0d", i, tr[i], e[i]);
         end
      end
      nvec++;
      if (tr[10] !== 4'd9 || n_id != 1 || n_mem != 4) begin
         nerr++; $display("FAIL to_skip_escrita: last=%0d id=%0d mem=%0d want 9/1/4", tr[10], n_id, n_mem);
      end
      nvec++;
      if (erro_mem !== 1'b1) begin nerr++; $display("FAIL to_erro: got %b want 1", erro_mem); end
      capture(6'b000000, 0, 0, 0);
      nvec++;
      if (erro_mem !== 1'b1 || tr_len != 8) begin
         nerr++; $display("FAIL to_sticky: erro=%b len=%0d want 1/8", erro_mem, tr_len);
      end
      nvec++;
      if (num_after !== 32'd6) begin nerr++; $display("FAIL to_count: got %0d want 6", num_after); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      opcode = 6'b000000;
      while (fase !== 4'd6 && n < 40) begin @(negedge clk); n++; end
      nvec++;
      if (n >= 40) begin nerr++; $display("FAIL mid_reach_exec: fase=%0d want 6", fase); end
      #2 reset = 1'b0;
      #1;
      nvec++;
      if ({ifd, captura, co, id, pc_we, ic, alu, mem, fim_instr} !== 9'd0 || fase !== 4'd0) begin
         nerr++; $display("FAIL mid_reset_outputs: enables=%b fase=%0d want 0/0",
            {ifd, captura, co, id, pc_we, ic, alu, mem, fim_instr}, fase);
      end
      nvec++;
      if (num_instr !== 32'd0 || erro_mem !== 1'b0) begin
         nerr++; $display("FAIL mid_reset_counters: num=%0d erro=%b want 0/0", num_instr, erro_mem);
      end
      @(negedge clk);
      reset = 1'b1; habilita = 1'b1;
      @(negedge clk);
      nvec++;
      if (ifd !== 1'b1 || fase !== 4'd1 || num_instr !== 32'd0) begin
         nerr++; $display("FAIL mid_restart: ifd=%b fase=%0d num=%0d want 1/1/0", ifd, fase, num_instr);
      end
   endtask

   task automatic test_wrap();
      capture(6'b000000, 0, 1, 1);
      nvec++;
      if (tr_len != 8 || n_fim != 1) begin
         nerr++; $display("FAIL wrap_complete: len=%0d fim=%0d want 8/1", tr_len, n_fim);
      end
      nvec++;
      if (num_after !== 32'd0) begin nerr++; $display("FAIL wrap_count: got %h want 0", num_after); end
      nvec++;
      if (fase_after !== 4'd0) begin nerr++; $display("FAIL wrap_park: fase=%0d want 0", fase_after); end
      @(negedge clk); @(negedge clk);
      nvec++;
      if (fase !== 4'd0 || ifd !== 1'b0) begin
         nerr++; $display("FAIL wrap_stay_idle: fase=%0d ifd=%b want 0/0", fase, ifd);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_sw();
      test_beq();
      test_timeout();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
